led_scan_scheduler: RTL and testbench
=====================================

Name: led_scan_scheduler

Overview:
- Sequences 8x8 LED matrix row multiplexing for the snake game.
- Captures a frame from game logic through a valid/ack handshake into a shadow buffer, then scans rows out to the cathode/anode pins with anti-ghost blanking.
- Blinks one selected LED (the snake head) in game-over.
- Sits between the game-logic datapath (out_led_array_flat producer) and the matrix pins.

Parameters:
- DWELL_CYCLES, 1, clock cycles each row stays lit; legal range is 1 or more.
- BLINK_FRAMES, 2, completed frames per blink half-period; legal range is 1 or more.

Ports:
- in_clka  input  1  system clock; all state updates on its rising edge.
- in_restart  input  1  reset, synchronous, active-high.
- in_frame_flat  input  64  frame from logic; bit [r*8+c] maps to row r, column c.
- in_frame_valid  input  1  logic offers a new frame; held until ack.
- out_frame_ack  output  1  one-cycle pulse, frame captured.
- in_blink_en  input  1  game-over blink request.
- in_blink_index  input  6  LED index to blink, as {row[2:0], col[2:0]}.
- out_row_cathode  output  8  active-low one-hot row select.
- out_column_anode  output  8  active-high column drive.
- out_row_index  output  3  row currently scanned.
- out_frame_done  output  1  one-cycle pulse at end of frame.
- out_scan_state  output  2  FSM state: 0 IDLE, 1 LOAD, 2 SCAN, 3 BLANK.

Behaviour:
- Reset (in_restart=1 at an edge) sets:
  - state IDLE, row 0, dwell counter 0;
  - shadow buffer 0, blink latch 0, blink phase 0, frame counter 0;
  - cathode 8'hFF, anode 8'h00, ack 0, done 0.
- Reset mid-operation aborts the scan immediately. No ack or done is issued.
- All outputs are decoded from registered state only. There is no combinational path from any input to any output.
- IDLE (1 cycle, frame boundary):
  - Latch in_blink_en and in_blink_index.
  - If in_frame_valid=1: capture in_frame_flat into the shadow buffer, go to LOAD.
  - Otherwise go to SCAN, reusing the shadow buffer (continuous refresh).
- LOAD (1 cycle): out_frame_ack=1, then go to SCAN with row 0.
- in_frame_valid outside IDLE is ignored. Logic must hold valid until ack.
- If valid is still high at the next IDLE, the frame is recaptured and re-acked.
- SCAN:
  - out_row_cathode = ~(1<<row).
  - out_column_anode = shadow[row*8+7 : row*8], with the blink mask applied.
  - The dwell counter runs DWELL_CYCLES cycles, then the FSM goes to BLANK.
- BLANK (1 cycle): cathode 8'hFF, anode 8'h00.
  - If row<7: row+1, go to SCAN.
  - If row==7: row 0, out_frame_done=1 this cycle, blink timer advances, go to IDLE.
- Frame period:
  - without a load: 1+8*(DWELL_CYCLES+1) cycles, i.e. 17 at defaults;
  - with a load: one extra cycle, i.e. 18 at defaults.
- Blink:
  - The frame counter counts completed frames while the blink latch is 1.
  - It wraps at BLINK_FRAMES-1 and toggles the phase on wrap.
  - When latch=1 and phase=1, the anode bit at the latched index is forced to 0. All other bits are unaffected.
  - When the latch is 0, counter and phase are cleared at that boundary.
- out_scan_state reflects the registered state.

Decomposition:
- Package snake_pkg holds:
  - scan state encodings (IDLE/LOAD/SCAN/BLANK);
  - constants MATRIX_ROWS=8, MATRIX_COLS=8, LED_INDEX_W=6;
  - an index-to-{row,col} split helper.
- Sub-module scan_blink_timer: frame counter plus phase toggle.
  - Inputs: clock, reset, frame_done, blink latch.
  - Output: phase.

Test Plan:
- Reset: in_restart=1 for one edge, mid-scan at row 4 -> next cycle state 0, row 0, cathode FF, anode 00, ack 0, done 0; subsequent frame scans all-zero anodes.
- Load: frame 64'h0000_0000_0000_0018, valid=1 at IDLE -> ack pulse in cycle 2. Row 0 shows cathode FE / anode 18 for 1 cycle, then FF/00. Rows 1..7 show anode 00. Done pulses in cycle 18.
- Refresh without valid: after the load above, valid=0 -> identical scan repeats with a 17-cycle period and no ack.
- Late valid: assert valid with 64'hFF00_0000_0000_0000 during row 2 SCAN -> no ack this frame. Ack comes at the next IDLE+1. Row 7 anode FF in the following scan.
- Blink: frame bit 29 set, blink_en=1, index 6'd29, BLINK_FRAMES=2 -> row 3 anode 0x20 in frames 0-1, 0x00 in frames 2-3, 0x20 in frames 4-5. Deassert blink_en -> 0x20 steady from the next frame.
- DWELL_CYCLES=3: each row is lit for exactly 3 cycles, then 1 blank cycle; frame period is 33 cycles.

Source files
------------

// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared scan state encodings, matrix geometry and index helper
package snake_pkg;

  localparam int MATRIX_ROWS = 8;
  localparam int MATRIX_COLS = 8;
  localparam int LED_INDEX_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SCAN  = 2'd2,
    ST_BLANK = 2'd3
  } scan_state_t;

  typedef struct packed {
    logic [2:0] row;
    logic [2:0] col;
  } led_pos_t;

  function automatic led_pos_t split_index(input logic [LED_INDEX_W-1:0] idx);
    led_pos_t pos;
    pos.row = idx[5:3];
    pos.col = idx[2:0];
    return pos;
  endfunction

endpackage

// File: rtl/scan_blink_timer.sv
// rtl/scan_blink_timer.sv - counts completed frames and toggles the blink phase on wrap
module scan_blink_timer
  import snake_pkg::*;
#(
  parameter int BLINK_FRAMES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic frame_done,
  input  logic latch,
  output logic phase
);

  localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_FRAMES - 1);

  logic [CW-1:0] cnt_q;
  logic          phase_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (frame_done) begin
      // A frame ending with blink disabled restarts the cadence from a lit phase.
      if (!latch) begin
        cnt_q   <= '0;
        phase_q <= 1'b0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_q   <= '0;
        phase_q <= ~phase_q;
      end else begin
        cnt_q   <= cnt_q + CW'(1);
      end
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/led_scan_scheduler.sv
// rtl/led_scan_scheduler.sv - 8x8 LED row scan with frame capture, blanking and head blink
module led_scan_scheduler
  import snake_pkg::*;
#(
  parameter int DWELL_CYCLES = 1,
  parameter int BLINK_FRAMES = 2
) (
  input  logic        in_clka,
  input  logic        in_restart,
  input  logic [63:0] in_frame_flat,
  input  logic        in_frame_valid,
  output logic        out_frame_ack,
  input  logic        in_blink_en,
  input  logic [5:0]  in_blink_index,
  output logic [7:0]  out_row_cathode,
  output logic [7:0]  out_column_anode,
  output logic [2:0]  out_row_index,
  output logic        out_frame_done,
  output logic [1:0]  out_scan_state
);

  localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);

  scan_state_t            state_q, state_d;
  logic [2:0]             row_q, row_d;
  logic [DW-1:0]          dwell_q, dwell_d;
  logic [63:0]            shadow_q;
  logic                   capture;
  logic                   blink_latch_q;
  logic [LED_INDEX_W-1:0] blink_idx_q;
  logic                   blink_phase;
  logic                   frame_done;
  logic [7:0]             row_bits;
  led_pos_t               head;

  always_ff @(posedge in_clka) begin
    if (in_restart) begin
      state_q       <= ST_IDLE;
      row_q         <= 3'd0;
      dwell_q       <= '0;
      shadow_q      <= 64'd0;
      blink_latch_q <= 1'b0;
      blink_idx_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      dwell_q <= dwell_d;
      if (capture) shadow_q <= in_frame_flat;
      // Blink request is only sampled at the frame boundary so a frame never changes mid-scan.
      if (state_q == ST_IDLE) begin
        blink_latch_q <= in_blink_en;
        blink_idx_q   <= in_blink_index;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    dwell_d = dwell_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        row_d   = 3'd0;
        dwell_d = '0;
        if (in_frame_valid) begin
          capture = 1'b1;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_SCAN;
        end
      end
      ST_LOAD: begin
        row_d   = 3'd0;
        dwell_d = '0;
        state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          state_d = ST_BLANK;
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end
      ST_BLANK: begin
        if (row_q == 3'd7) begin
          row_d   = 3'd0;
          state_d = ST_IDLE;
        end else begin
          row_d   = row_q + 3'd1;
          state_d = ST_SCAN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign frame_done = (state_q == ST_BLANK) && (row_q == 3'd7);

  scan_blink_timer #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink_timer (
    .clk       (in_clka),
    .reset     (in_restart),
    .frame_done(frame_done),
    .latch     (blink_latch_q),
    .phase     (blink_phase)
  );

  always_comb begin
    head     = split_index(blink_idx_q);
    row_bits = shadow_q[{row_q, 3'b000} +: 8];
    if (blink_latch_q && blink_phase && (head.row == row_q)) row_bits[head.col] = 1'b0;
    out_row_cathode  = 8'hFF;
    out_column_anode = 8'h00;
    if (state_q == ST_SCAN) begin
      out_row_cathode  = ~(8'h01 << row_q);
      out_column_anode = row_bits;
    end
  end

  assign out_frame_ack  = (state_q == ST_LOAD);
  assign out_frame_done = frame_done;
  assign out_row_index  = row_q;
  assign out_scan_state = state_q;

endmodule

// File: tb/tb_led_scan_scheduler.sv
// tb/tb_led_scan_scheduler.sv - scoreboard bench for led_scan_scheduler (dwell 1 and dwell 3)
module tb_led_scan_scheduler;

  typedef struct packed {
    logic [1:0] st;
    logic [2:0] row;
    logic [7:0] cath;
    logic [7:0] an;
    logic       ack;
    logic       done;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        restart, valid, ack, blink_en, done;
  logic [63:0] frame;
  logic [5:0]  bidx;
  logic [7:0]  cath, an;
  logic [2:0]  row;
  logic [1:0]  st;

  logic        restart3, valid3, ack3, blink_en3, done3;
  logic [63:0] frame3;
  logic [5:0]  bidx3;
  logic [7:0]  cath3, an3;
  logic [2:0]  row3;
  logic [1:0]  st3;

  led_scan_scheduler #(.DWELL_CYCLES(1), .BLINK_FRAMES(2)) dut (
    .in_clka(clk), .in_restart(restart), .in_frame_flat(frame), .in_frame_valid(valid),
    .out_frame_ack(ack), .in_blink_en(blink_en), .in_blink_index(bidx),
    .out_row_cathode(cath), .out_column_anode(an), .out_row_index(row),
    .out_frame_done(done), .out_scan_state(st)
  );

  led_scan_scheduler #(.DWELL_CYCLES(3), .BLINK_FRAMES(2)) dut3 (
    .in_clka(clk), .in_restart(restart3), .in_frame_flat(frame3), .in_frame_valid(valid3),
    .out_frame_ack(ack3), .in_blink_en(blink_en3), .in_blink_index(bidx3),
    .out_row_cathode(cath3), .out_column_anode(an3), .out_row_index(row3),
    .out_frame_done(done3), .out_scan_state(st3)
  );

  ev_t q0[$];
  ev_t q3[$];
  int  checks = 0;
  int  errors = 0;
  int  ncyc = 0;
  bit  drain_req = 1'b0;
  bit  drained = 1'b0;

  function automatic ev_t mk(input logic [1:0] s, input logic [2:0] r, input logic [7:0] c,
                             input logic [7:0] a, input logic k, input logic d);
    ev_t e;
    e.st = s; e.row = r; e.cath = c; e.an = a; e.ack = k; e.done = d;
    return e;
  endfunction

  task automatic push_ev(input bit which3, input ev_t e, inout int n, input int max_n);
    if (n < max_n) begin
      if (which3) q3.push_back(e);
      else q0.push_back(e);
    end
    n++;
  endtask

  // Expected cycle-by-cycle outputs of one frame; vis is the anode pattern after blink masking.
  task automatic push_frame(input bit which3, input int dwell, input bit load,
                            input logic [63:0] vis, input int max_n);
    int n;
    logic [7:0] one;
    n = 0;
    one = 8'h01;
    push_ev(which3, mk(2'd0, 3'd0, 8'hFF, 8'h00, 1'b0, 1'b0), n, max_n);
    if (load) push_ev(which3, mk(2'd1, 3'd0, 8'hFF, 8'h00, 1'b1, 1'b0), n, max_n);
    for (int r = 0; r < 8; r++) begin
      for (int d = 0; d < dwell; d++)
        push_ev(which3, mk(2'd2, 3'(r), ~(one << r), vis[r*8 +: 8], 1'b0, 1'b0), n, max_n);
      push_ev(which3, mk(2'd3, 3'(r), 8'hFF, 8'h00, 1'b0, r == 7), n, max_n);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic compare(input string name, input ev_t a, input ev_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s cyc%0d got st=%0d row=%0d cath=%h an=%h ack=%b done=%b want st=%0d row=%0d cath=%h an=%h ack=%b done=%b",
               name, ncyc, a.st, a.row, a.cath, a.an, a.ack, a.done,
               e.st, e.row, e.cath, e.an, e.ack, e.done);
    end
  endtask

  always @(negedge clk) begin
    ncyc++;
    if (q0.size() > 0) compare("scan_d1", mk(st, row, cath, an, ack, done), q0.pop_front());
    if (q3.size() > 0) compare("scan_d3", mk(st3, row3, cath3, an3, ack3, done3), q3.pop_front());
    if (drain_req && !drained) begin
      drained = 1'b1;
      checks++;
      if (q0.size() + q3.size() != 0) begin
        errors++;
        $display("FAIL drain leftover=%0d required=0", q0.size() + q3.size());
      end
    end
  end

  initial begin
    restart = 1'b1; valid = 1'b0; frame = 64'd0; blink_en = 1'b0; bidx = 6'd0;
    restart3 = 1'b1; valid3 = 1'b0; frame3 = 64'd0; blink_en3 = 1'b0; bidx3 = 6'd0;
    wait_cyc(3);
    fork
      begin
        restart = 1'b0;
        // Load, then two refresh frames; valid raised during row 2 of the second one.
        valid = 1'b1; frame = 64'h0000_0000_0000_0018;
        push_frame(1'b0, 1, 1'b1, 64'h18, 1000);
        wait_cyc(1); valid = 1'b0; wait_cyc(17);
        push_frame(1'b0, 1, 1'b0, 64'h18, 1000);
        wait_cyc(17);
        push_frame(1'b0, 1, 1'b0, 64'h18, 1000);
        wait_cyc(5); valid = 1'b1; frame = 64'hFF00_0000_0000_0000; wait_cyc(12);
        push_frame(1'b0, 1, 1'b1, 64'hFF00_0000_0000_0000, 1000);
        wait_cyc(1); valid = 1'b0; wait_cyc(17);
        // Blink on LED 29 (row 3, column 5).
        valid = 1'b1; frame = 64'h0000_0000_2000_0000; blink_en = 1'b1; bidx = 6'd29;
        push_frame(1'b0, 1, 1'b1, 64'h0000_0000_2000_0000, 1000);
        wait_cyc(1); valid = 1'b0; wait_cyc(17);
        push_frame(1'b0, 1, 1'b0, 64'h0000_0000_2000_0000, 1000); wait_cyc(17);
        push_frame(1'b0, 1, 1'b0, 64'h0, 1000); wait_cyc(17);
        push_frame(1'b0, 1, 1'b0, 64'h0, 1000); wait_cyc(17);
        push_frame(1'b0, 1, 1'b0, 64'h0000_0000_2000_0000, 1000); wait_cyc(17);
        push_frame(1'b0, 1, 1'b0, 64'h0000_0000_2000_0000, 1000);
        wait_cyc(2); blink_en = 1'b0; wait_cyc(15);
        push_frame(1'b0, 1, 1'b0, 64'h0000_0000_2000_0000, 1000); wait_cyc(17);
        push_frame(1'b0, 1, 1'b0, 64'h0000_0000_2000_0000, 1000); wait_cyc(17);
        // Reset while row 4 is lit: scan aborts, shadow cleared.
        push_frame(1'b0, 1, 1'b0, 64'h0000_0000_2000_0000, 10);
        wait_cyc(9); restart = 1'b1; wait_cyc(1); restart = 1'b0;
        push_frame(1'b0, 1, 1'b0, 64'h0, 1000);
        wait_cyc(17);
      end
      begin
        restart3 = 1'b0;
        valid3 = 1'b1; frame3 = 64'h0000_3C00_0000_0081;
        push_frame(1'b1, 3, 1'b1, 64'h0000_3C00_0000_0081, 1000);
        wait_cyc(1); valid3 = 1'b0; wait_cyc(33);
        push_frame(1'b1, 3, 1'b0, 64'h0000_3C00_0000_0081, 1000);
        wait_cyc(33);
      end
    join
    wait_cyc(2);
    drain_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
